// File: rtl/mem_req_queue.sv
// mem_req_queue: round-robin collects cache fill/writeback requests into
// one in-order FIFO and issues them one at a time to the memory controller.
module mem_req_queue #(
  parameter int NUM_CACHES = 2,
  parameter int DEPTH      = 4,
  localparam int CW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1,
  localparam int PW = $clog2(DEPTH),
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CACHES-1:0]    IN_req_valid,
  input  logic [NUM_CACHES-1:0]    IN_req_we,
  input  logic [NUM_CACHES*10-1:0] IN_req_sramAddr,
  input  logic [NUM_CACHES*30-1:0] IN_req_extAddr,
  output logic [NUM_CACHES-1:0]    OUT_req_ready,
  output logic [NUM_CACHES-1:0]    OUT_pending,
  output logic [NUM_CACHES-1:0]    OUT_done,
  output logic                     OUT_MC_ce,
  output logic                     OUT_MC_we,
  output logic [CW-1:0]            OUT_MC_cacheID,
  output logic [9:0]               OUT_MC_sramAddr,
  output logic [29:0]              OUT_MC_extAddr,
  input  logic                     IN_MC_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAITB,
    S_ACTIVE
  } state_t;

  function automatic logic [CW-1:0] f_wrap(
    input logic [CW-1:0] a,
    input int            k
  );
    int s;
    s = int'(a) + k;
    if (s >= NUM_CACHES) s = s - NUM_CACHES;
    return CW'(s);
  endfunction

  state_t r_state;

  logic [CW-1:0] r_rr;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [NW-1:0] r_cnt;

  logic          r_qwe   [DEPTH];
  logic [CW-1:0] r_qid   [DEPTH];
  logic [9:0]    r_qsram [DEPTH];
  logic [29:0]   r_qext  [DEPTH];

  logic [NW-1:0] r_pend [NUM_CACHES];

  logic                  r_mc_ce;
  logic                  r_mc_we;
  logic [CW-1:0]         r_mc_id;
  logic [9:0]            r_mc_sram;
  logic [29:0]           r_mc_ext;
  logic [NUM_CACHES-1:0] r_done;

  logic                  w_found;
  logic [CW-1:0]         w_idx;
  logic [CW-1:0]         w_gid;
  logic                  w_space;
  logic                  w_push;
  logic                  w_pop;
  logic [NUM_CACHES-1:0] w_pinc;
  logic [NUM_CACHES-1:0] w_pdec;
  logic                  w_gwe;
  logic [9:0]            w_gsram;
  logic [29:0]           w_gext;
  logic [CW-1:0]         w_hid;

  // First valid port at or above the round-robin pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CACHES; k++) begin
      w_idx = f_wrap(r_rr, k);
      if (!w_found && IN_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
    end
  end

  assign w_space = r_cnt < NW'(DEPTH);
  assign w_push  = !rst && w_space && w_found;
  assign w_pinc  = w_push ? (NUM_CACHES'(1) << w_gid) : '0;
  assign OUT_req_ready = w_pinc;

  assign w_gwe   = IN_req_we[w_gid];
  assign w_gsram = IN_req_sramAddr[int'(w_gid)*10 +: 10];
  assign w_gext  = IN_req_extAddr[int'(w_gid)*30 +: 30];

  assign w_hid  = r_qid[r_rd];
  assign w_pop  = (r_state == S_ACTIVE) && !IN_MC_busy;
  assign w_pdec = w_pop ? (NUM_CACHES'(1) << w_hid) : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qwe[r_wr]   <= w_gwe;
      r_qid[r_wr]   <= w_gid;
      r_qsram[r_wr] <= w_gsram;
      r_qext[r_wr]  <= w_gext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_rr  <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
        r_rr <= f_wrap(w_gid, 1);
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (rst) r_pend[i] <= '0;
      else if (w_pinc[i] && !w_pdec[i]) r_pend[i] <= r_pend[i] + 1'b1;
      else if (w_pdec[i] && !w_pinc[i]) r_pend[i] <= r_pend[i] - 1'b1;
    end
  end

  always_comb begin
    OUT_pending = '0;
    for (int i = 0; i < NUM_CACHES; i++)
      OUT_pending[i] = r_pend[i] != '0;
  end

  // ce is a single-cycle strobe; the address fields hold until next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mc_ce   <= 1'b0;
      r_mc_we   <= 1'b0;
      r_mc_id   <= '0;
      r_mc_sram <= '0;
      r_mc_ext  <= '0;
      r_done    <= '0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (r_cnt != '0 && !IN_MC_busy) begin
            r_mc_ce   <= 1'b1;
            r_mc_we   <= r_qwe[r_rd];
            r_mc_id   <= w_hid;
            r_mc_sram <= r_qsram[r_rd];
            r_mc_ext  <= r_qext[r_rd];
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mc_ce <= 1'b0;
          r_state <= S_WAITB;
        end
        S_WAITB: begin
          if (IN_MC_busy) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_pop) begin
            r_done  <= w_pdec;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign OUT_MC_ce       = r_mc_ce;
  assign OUT_MC_we       = r_mc_we;
  assign OUT_MC_cacheID  = r_mc_id;
  assign OUT_MC_sramAddr = r_mc_sram;
  assign OUT_MC_extAddr  = r_mc_ext;
  assign OUT_done        = r_done;

endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed bench for mem_req_queue with a small
// memory-controller busy model.
module tb_mem_req_queue;

  logic        clk;
  logic        rst;
  logic [1:0]  valid;
  logic [1:0]  we;
  logic [19:0] sram;
  logic [59:0] ext;
  logic [1:0]  ready;
  logic [1:0]  pending;
  logic [1:0]  done;
  logic        mc_ce;
  logic        mc_we;
  logic [0:0]  mc_id;
  logic [9:0]  mc_sram;
  logic [29:0] mc_ext;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int   mc_cnt = 0;
  int   busy_len = 3;
  logic hold = 1'b0;
  logic ext_busy = 1'b0;

  logic        ce_we  [$];
  int          ce_id  [$];
  logic [29:0] ce_ext [$];
  time         ce_t   [$];
  int          done_log [$];
  time         done_t   [$];

  mem_req_queue #(.NUM_CACHES(2), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_req_valid   (valid),
    .IN_req_we      (we),
    .IN_req_sramAddr(sram),
    .IN_req_extAddr (ext),
    .OUT_req_ready  (ready),
    .OUT_pending    (pending),
    .OUT_done       (done),
    .OUT_MC_ce      (mc_ce),
    .OUT_MC_we      (mc_we),
    .OUT_MC_cacheID (mc_id),
    .OUT_MC_sramAddr(mc_sram),
    .OUT_MC_extAddr (mc_ext),
    .IN_MC_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) mc_cnt <= 0;
    else if (mc_ce) mc_cnt <= busy_len;
    else if (mc_cnt != 0 && !hold) mc_cnt <= mc_cnt - 1;
  end
  assign busy = (mc_cnt != 0) || ext_busy;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(mc_ce && (done != 2'b00))) else begin
        errors++;
        $error("FAIL done_with_ce obs ce=%b done=%b exp no overlap",
               mc_ce, done);
      end
    end
    if (mc_ce) begin
      ce_we.push_back(mc_we);
      ce_id.push_back(int'(mc_id));
      ce_ext.push_back(mc_ext);
      ce_t.push_back($time);
    end
    for (int i = 0; i < 2; i++)
      if (done[i]) begin
        done_log.push_back(i);
        done_t.push_back($time);
      end
  end

  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ce_we.delete();
    ce_id.delete();
    ce_ext.delete();
    ce_t.delete();
    done_log.delete();
    done_t.delete();
  endtask

  task automatic set_req(input int p, input logic v, input logic w,
                         input logic [9:0] s, input logic [29:0] e);
    valid[p]       = v;
    we[p]          = w;
    sram[p*10+:10] = s;
    ext[p*30+:30]  = e;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int  ndone;
    bit  found;
    bit  pend_ok;

    rst = 1'b1; valid = 0; we = 0; sram = 0; ext = 0;
    tick();
    tick();
    valid = 2'b01;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_ce", mc_ce, 0);
    chk("rst_done", done, 0);
    chk("rst_pend", pending, 0);
    chk("rst_mc", {mc_we, mc_id, mc_sram, mc_ext}, 0);
    valid = 2'b00;
    rst = 1'b0;
    clear_logs();

    // Test 1: single fill on port 0
    tick();
    set_req(0, 1'b1, 1'b0, 10'h040, 30'h1000);
    #1;
    chk("t1_ready0", ready, 2'b01);
    tick();
    valid = 2'b00;
    chk("t1_ce_c1", mc_ce, 0);
    tick();
    chk("t1_ce_c2", mc_ce, 1);
    chk("t1_id", mc_id, 0);
    chk("t1_ext", mc_ext, 30'h1000);
    chk("t1_sram", mc_sram, 10'h040);
    chk("t1_we", mc_we, 0);
    chk("t1_pend", pending, 2'b01);
    tick();
    chk("t1_ce_c3", mc_ce, 0);
    chk("t1_busy", busy, 1);
    tick(); tick(); tick();
    chk("t1_busy_fall", busy, 0);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 2'b01);
    tick();
    chk("t1_done_clr", done, 0);
    chk("t1_pend_clr", pending, 0);

    // Test 2: simultaneous requests from rrPtr=0
    do_reset();
    set_req(0, 1'b1, 1'b0, 10'h001, 30'h0A0);
    set_req(1, 1'b1, 1'b0, 10'h002, 30'h0B0);
    #1;
    chk("t2_ready_c0", ready, 2'b01);
    tick();
    valid[0] = 1'b0;
    #1;
    chk("t2_ready_c1", ready, 2'b10);
    tick();
    valid = 2'b00;
    repeat (40) tick();
    chk("t2_ce_n", ce_id.size(), 2);
    if (ce_id.size() == 2) begin
      chk("t2_ce_0", ce_id[0], 0);
      chk("t2_ce_1", ce_id[1], 1);
    end
    chk("t2_done_n", done_log.size(), 2);
    if (done_log.size() == 2) begin
      chk("t2_done_0", done_log[0], 0);
      chk("t2_done_1", done_log[1], 1);
    end

    // Test 3: fill the queue while the controller stays busy
    do_reset();
    hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_req(1, 1'b1, 1'b1, 10'(c), 30'h100 + 30'(c));
      #1;
      chk("t3_fill_ready", ready, 2'b10);
      tick();
    end
    set_req(1, 1'b1, 1'b1, 10'h4, 30'h104);
    #1;
    chk("t3_full_ready", ready, 0);
    tick();
    chk("t3_full_ready2", ready, 0);
    chk("t3_busy_held", busy, 1);
    hold = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (done[1]) found = 1;
      else chk("t3_wait_ready", ready, 0);
    end
    chk("t3_done_seen", found, 1);
    chk("t3_fifth_ready", ready, 2'b10);
    tick();
    valid = 2'b00;
    repeat (60) tick();
    chk("t3_ce_n", ce_ext.size(), 5);
    if (ce_ext.size() == 5)
      for (int i = 0; i < 5; i++)
        chk("t3_order", ce_ext[i], 30'h100 + 30'(i));
    chk("t3_pend_end", pending, 0);

    // Test 4: writeback then fill to the same line on port 1
    do_reset();
    valid[0] = 1'b0;
    we[0] = 1'bx;
    sram[9:0] = 'x;
    ext[29:0] = 'x;
    set_req(1, 1'b1, 1'b1, 10'h010, 30'h2A0);
    #1;
    chk("t4_ready_wb", ready, 2'b10);
    tick();
    set_req(1, 1'b1, 1'b0, 10'h020, 30'h2A0);
    #1;
    chk("t4_ready_fill", ready, 2'b10);
    tick();
    valid = 2'b00;
    ndone = 0;
    pend_ok = 1;
    for (int i = 0; i < 40; i++) begin
      if (done[1]) ndone++;
      if (ndone < 2 && !pending[1]) pend_ok = 0;
      tick();
    end
    chk("t4_pend_held", pend_ok, 1);
    chk("t4_ndone", ndone, 2);
    chk("t4_ce_n", ce_we.size(), 2);
    if (ce_we.size() == 2 && done_t.size() == 2) begin
      chk("t4_we_first", ce_we[0], 1);
      chk("t4_we_second", ce_we[1], 0);
      chk("t4_fill_after_done", ce_t[1] > done_t[0], 1);
    end
    chk("t4_pend_end", pending, 0);
    we = 0; sram = 0; ext = 0;

    // Test 5: reset while a transfer is active with 3 entries queued
    do_reset();
    hold = 1'b1;
    set_req(0, 1'b1, 1'b0, 10'h0, 30'h500);
    tick();
    valid = 2'b00;
    set_req(1, 1'b1, 1'b0, 10'h0, 30'h501);
    tick();
    valid = 2'b00;
    set_req(0, 1'b1, 1'b0, 10'h0, 30'h502);
    tick();
    valid = 2'b00;
    tick();
    tick();
    chk("t5_busy", busy, 1);
    chk("t5_pend_pre", pending, 2'b11);
    rst = 1'b1;
    valid = 2'b01;
    tick();
    #1;
    chk("t5_ready_rst", ready, 0);
    chk("t5_ce", mc_ce, 0);
    chk("t5_pend", pending, 0);
    chk("t5_done", done, 0);
    chk("t5_ext_clr", mc_ext, 0);
    rst = 1'b0;
    valid = 2'b00;
    hold = 1'b0;
    clear_logs();
    repeat (6) tick();
    chk("t5_no_done", done_log.size(), 0);
    chk("t5_no_ce", ce_ext.size(), 0);
    set_req(1, 1'b1, 1'b0, 10'h33, 30'h3333);
    tick();
    valid = 2'b00;
    repeat (30) tick();
    chk("t5_new_ce_n", ce_ext.size(), 1);
    chk("t5_new_ext", (ce_ext.size() > 0) ? ce_ext[0] : 30'h0, 30'h3333);
    chk("t5_new_done_n", done_log.size(), 1);
    chk("t5_new_done", (done_log.size() > 0) ? done_log[0] : -1, 1);

    // Test 6: controller already owned by someone else
    do_reset();
    ext_busy = 1'b1;
    set_req(0, 1'b1, 1'b1, 10'h066, 30'h6666);
    tick();
    valid = 2'b00;
    repeat (6) tick();
    chk("t6_no_ce", ce_ext.size(), 0);
    chk("t6_pend", pending, 2'b01);
    ext_busy = 1'b0;
    tick();
    chk("t6_ce", mc_ce, 1);
    chk("t6_ext", mc_ext, 30'h6666);
    repeat (12) tick();
    chk("t6_done_n", done_log.size(), 1);
    chk("t6_pend_end", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
